// File: rtl/cond_flag_unit.sv
// cond_flag_unit
//   Execute-stage consumer of the ALU flag interface. Holds the architectural NZCV flag
//   register, evaluates each instruction's ARM-style condition field against it, gates the
//   instruction's branch / register-write / memory-write requests, and latches the new
//   ALU flags for instructions that pass their condition and ask for a flag update.
//   All outputs are registered and appear one cycle after the instruction is accepted.
//
// Parameters
//   SQ_CNT_W  width of the saturating squashed-instruction counter
//   FLAG_RST  reset value of the flag register {N,Z,C,V}
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset, dominates stall and in_valid
//   in_valid   an execute-stage instruction is present this cycle
//   stall      freeze: every register holds
//   Cond       4-bit condition field
//   FlagW      [1] update N,Z  [0] update C,V
//   ALUFlag    {N,Z,C,V} produced by the ALU for this instruction
//   PCS        branch request
//   RegW       register-write request
//   MemW       memory-write request
//   NoWrite    compare-type op: never write the register file
//   out_valid  registered outputs belong to an accepted instruction
//   PCSrc      gated branch
//   RegWrite   gated register write
//   MemWrite   gated memory write
//   CondEx     condition result of the registered instruction
//   Flags      current flag register {N,Z,C,V}
//   sq_count   count of accepted instructions whose condition failed (saturating)

module cond_flag_unit #(
  parameter int unsigned SQ_CNT_W = 16,
  parameter logic [3:0]  FLAG_RST = 4'b0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                stall,
  input  logic [3:0]          Cond,
  input  logic [1:0]          FlagW,
  input  logic [3:0]          ALUFlag,
  input  logic                PCS,
  input  logic                RegW,
  input  logic                MemW,
  input  logic                NoWrite,
  output logic                out_valid,
  output logic                PCSrc,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic                CondEx,
  output logic [3:0]          Flags,
  output logic [SQ_CNT_W-1:0] sq_count
);

  logic [3:0]          flags_q;
  logic                out_valid_q;
  logic                pc_src_q;
  logic                reg_write_q;
  logic                mem_write_q;
  logic                cond_ex_q;
  logic [SQ_CNT_W-1:0] sq_count_q;

  logic flag_n, flag_z, flag_c, flag_v;
  logic cex;
  logic accept;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  assign accept = in_valid & ~stall;

  // Condition uses the registered flags only: an instruction never sees its own update,
  // while the next instruction sees it because the register has already been written.
  always_comb begin
    cex = 1'b0;
    unique case (Cond)
      4'b0000: cex = flag_z;                                  // EQ
      4'b0001: cex = ~flag_z;                                 // NE
      4'b0010: cex = flag_c;                                  // CS
      4'b0011: cex = ~flag_c;                                 // CC
      4'b0100: cex = flag_n;                                  // MI
      4'b0101: cex = ~flag_n;                                 // PL
      4'b0110: cex = flag_v;                                  // VS
      4'b0111: cex = ~flag_v;                                 // VC
      4'b1000: cex = flag_c & ~flag_z;                        // HI
      4'b1001: cex = ~flag_c | flag_z;                        // LS
      4'b1010: cex = (flag_n == flag_v);                      // GE
      4'b1011: cex = (flag_n != flag_v);                      // LT
      4'b1100: cex = ~flag_z & (flag_n == flag_v);            // GT
      4'b1101: cex = flag_z | (flag_n != flag_v);             // LE
      4'b1110: cex = 1'b1;                                    // AL
      4'b1111: cex = 1'b0;                                    // NV
      default: cex = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= FLAG_RST;
      out_valid_q <= 1'b0;
      pc_src_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      cond_ex_q   <= 1'b0;
      sq_count_q  <= '0;
    end else if (!stall) begin
      if (accept) begin
        // A failed condition leaves the flags untouched whatever FlagW says.
        if (FlagW[1] && cex) flags_q[3:2] <= ALUFlag[3:2];
        if (FlagW[0] && cex) flags_q[1:0] <= ALUFlag[1:0];
        out_valid_q <= 1'b1;
        pc_src_q    <= PCS & cex;
        reg_write_q <= RegW & cex & ~NoWrite;
        mem_write_q <= MemW & cex;
        cond_ex_q   <= cex;
        if (!cex && (sq_count_q != {SQ_CNT_W{1'b1}})) sq_count_q <= sq_count_q + 1'b1;
      end else begin
        // Bubble: drop the gated outputs, keep architectural state.
        out_valid_q <= 1'b0;
        pc_src_q    <= 1'b0;
        reg_write_q <= 1'b0;
        mem_write_q <= 1'b0;
        cond_ex_q   <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign PCSrc     = pc_src_q;
  assign RegWrite  = reg_write_q;
  assign MemWrite  = mem_write_q;
  assign CondEx    = cond_ex_q;
  assign Flags     = flags_q;
  assign sq_count  = sq_count_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit. Counter width is reduced so saturation is reachable.
module tb_cond_flag_unit;
  localparam int unsigned SQW = 4;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           stall;
  logic [3:0]     Cond;
  logic [1:0]     FlagW;
  logic [3:0]     ALUFlag;
  logic           PCS;
  logic           RegW;
  logic           MemW;
  logic           NoWrite;
  logic           out_valid;
  logic           PCSrc;
  logic           RegWrite;
  logic           MemWrite;
  logic           CondEx;
  logic [3:0]     Flags;
  logic [SQW-1:0] sq_count;

  int errors = 0;
  int checks = 0;

  cond_flag_unit #(
    .SQ_CNT_W(SQW),
    .FLAG_RST(4'b0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .stall    (stall),
    .Cond     (Cond),
    .FlagW    (FlagW),
    .ALUFlag  (ALUFlag),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .out_valid(out_valid),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags),
    .sq_count (sq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; stall = 1'b0; Cond = 4'b1110; FlagW = 2'b00; ALUFlag = 4'b0000;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
  endtask

  // Present one instruction for one accepted edge, then return to idle.
  task automatic issue(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                       input logic pcs_i, input logic regw_i, input logic memw_i,
                       input logic nw_i);
    in_valid = 1'b1; Cond = c; FlagW = fw; ALUFlag = af;
    PCS = pcs_i; RegW = regw_i; MemW = memw_i; NoWrite = nw_i;
    step();
    idle_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic set_flags(input logic [3:0] f);
    issue(4'b1110, 2'b11, f, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    // Instruction presented during reset must be lost.
    reset = 1'b1; in_valid = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlag = 4'b1111;
    RegW = 1'b1; PCS = 1'b1; MemW = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    checks++;
    if (Flags !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", Flags);
    end
    checks++;
    if ({out_valid, PCSrc, RegWrite, MemWrite, CondEx} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outs: got %b want 00000", {out_valid, PCSrc, RegWrite, MemWrite, CondEx});
    end
    checks++;
    if (sq_count !== 4'd0) begin
      errors++; $display("FAIL reset_sq: got %0d want 0", sq_count);
    end
  endtask

  task automatic test_cmp_beq();
    do_reset();
    issue(4'b1110, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({out_valid, RegWrite, CondEx} !== 3'b101) begin
      errors++; $display("FAIL cmp_outs: got %b want 101", {out_valid, RegWrite, CondEx});
    end
    checks++;
    if (Flags !== 4'b0100) begin
      errors++; $display("FAIL cmp_flags: got %b want 0100", Flags);
    end
    issue(4'b0000, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({PCSrc, CondEx} !== 2'b11) begin
      errors++; $display("FAIL beq_taken: got %b want 11", {PCSrc, CondEx});
    end
    step();
    checks++;
    if ({out_valid, PCSrc, CondEx} !== 3'b000) begin
      errors++; $display("FAIL bubble_clear: got %b want 000", {out_valid, PCSrc, CondEx});
    end
  endtask

  task automatic test_squash();
    do_reset();
    issue(4'b0000, 2'b11, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({out_valid, RegWrite, MemWrite, CondEx} !== 4'b1000) begin
      errors++;
      $display("FAIL squash_outs: got %b want 1000", {out_valid, RegWrite, MemWrite, CondEx});
    end
    checks++;
    if (Flags !== 4'b0000) begin
      errors++; $display("FAIL squash_flags: got %b want 0000", Flags);
    end
    checks++;
    if (sq_count !== 4'd1) begin
      errors++; $display("FAIL squash_sq: got %0d want 1", sq_count);
    end
  endtask

  task automatic test_partial_write();
    do_reset();
    set_flags(4'b1010);
    issue(4'b1110, 2'b10, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (Flags !== 4'b0110) begin
      errors++; $display("FAIL partial_nz: got %b want 0110", Flags);
    end
    checks++;
    if (MemWrite !== 1'b1) begin
      errors++; $display("FAIL partial_memw: got %b want 1", MemWrite);
    end
    issue(4'b1110, 2'b01, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Flags !== 4'b0101) begin
      errors++; $display("FAIL partial_cv: got %b want 0101", Flags);
    end
  endtask

  task automatic test_conditions();
    logic [3:0] conds [10];
    logic [3:0] flg   [10];
    logic       exp   [10];
    // {flags, cond, expected} vectors, hand-evaluated.
    flg[0] = 4'b1001; conds[0] = 4'b1010; exp[0] = 1'b1;  // GE  N=V
    flg[1] = 4'b1001; conds[1] = 4'b1100; exp[1] = 1'b1;  // GT  !Z & N=V
    flg[2] = 4'b1001; conds[2] = 4'b1011; exp[2] = 1'b0;  // LT
    flg[3] = 4'b1001; conds[3] = 4'b1101; exp[3] = 1'b0;  // LE
    flg[4] = 4'b1000; conds[4] = 4'b1011; exp[4] = 1'b1;  // LT  N!=V
    flg[5] = 4'b1000; conds[5] = 4'b1010; exp[5] = 1'b0;  // GE
    flg[6] = 4'b0010; conds[6] = 4'b1000; exp[6] = 1'b1;  // HI  C & !Z
    flg[7] = 4'b0110; conds[7] = 4'b1001; exp[7] = 1'b1;  // LS  Z
    flg[8] = 4'b0001; conds[8] = 4'b0110; exp[8] = 1'b1;  // VS
    flg[9] = 4'b0000; conds[9] = 4'b1111; exp[9] = 1'b0;  // NV
    for (int i = 0; i < 10; i++) begin
      do_reset();
      set_flags(flg[i]);
      issue(conds[i], 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({CondEx, PCSrc} !== {exp[i], exp[i]}) begin
        errors++;
        $display("FAIL cond_%0d flags=%b cond=%b: got cex=%b pcsrc=%b want %b", i, flg[i],
                 conds[i], CondEx, PCSrc, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Z set, then EQ that itself clears Z: passes on old flags and commits its update.
    set_flags(4'b0100);
    issue(4'b0000, 2'b11, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({CondEx, RegWrite, Flags} !== 6'b110000) begin
      errors++; $display("FAIL b2b_self: got cex=%b rw=%b flags=%b want 1 1 0000",
                         CondEx, RegWrite, Flags);
    end
    // Two consecutive accepted instructions: second sees first's update.
    in_valid = 1'b1; Cond = 4'b1110; FlagW = 2'b10; ALUFlag = 4'b0100;
    step();
    Cond = 4'b0000; FlagW = 2'b00; PCS = 1'b1;
    step();
    idle_inputs();
    checks++;
    if ({out_valid, PCSrc, CondEx} !== 3'b111) begin
      errors++; $display("FAIL b2b_fwd: got %b want 111", {out_valid, PCSrc, CondEx});
    end
  endtask

  task automatic test_stall();
    do_reset();
    issue(4'b1111, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);  // squashed: sq=1
    set_flags(4'b0010);
    issue(4'b1110, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);   // RegWrite=1 pending
    stall = 1'b1; in_valid = 1'b1; Cond = 4'b0000; FlagW = 2'b11; ALUFlag = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({out_valid, RegWrite, CondEx, Flags, sq_count} !== {3'b111, 4'b0010, 4'd1}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v=%b rw=%b cex=%b flags=%b sq=%0d want 1 1 1 0010 1",
                 i, out_valid, RegWrite, CondEx, Flags, sq_count);
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    checks++;
    if ({out_valid, RegWrite, CondEx, Flags, sq_count} !== {3'b000, 4'b0000, 4'd0}) begin
      errors++;
      $display("FAIL stall_reset: got v=%b rw=%b cex=%b flags=%b sq=%0d want 0 0 0 0000 0",
               out_valid, RegWrite, CondEx, Flags, sq_count);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      issue(4'b1111, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 14 || i == 15 || i == 20) begin
        checks++;
        if (sq_count !== ((i < 15) ? 4'(i) : 4'd15)) begin
          errors++;
          $display("FAIL sat_%0d: got %0d want %0d", i, sq_count, (i < 15) ? i : 15);
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_cmp_beq();
    test_squash();
    test_partial_write();
    test_conditions();
    test_back_to_back();
    test_stall();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
